// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the memory subsystem: the RAM status encoding returned by
// the single-ported RAM, the arbiter FSM state encoding and the basic word
// type used on cache/RAM data and address buses.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_W_DEF = 32;

  typedef logic [WORD_W_DEF-1:0] word_t;

  // RAM status as driven on ramstate
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISERVE = 2'd1,
    DSERVE = 2'd2
  } arb_state_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serializes icache fetches and dcache loads/stores onto one single-ported
// RAM. The dcache has fixed priority; a starvation counter forces the icache
// ahead once it has been denied STARVE_MAX consecutive cycles. Every
// transaction ends in IDLE so back-to-back requests are always re-arbitrated.
//
// Ports:
//   CLK, nRST                  clock, asynchronous active-low reset
//   iREN, iaddr                icache read request and word address
//   iwait, iload               icache hold / returned instruction word
//   dREN, dWEN, daddr, dstore  dcache read/write request, address, write data
//   dwait, dload               dcache hold / returned data word
//   ramREN, ramWEN             RAM read/write enables
//   ramaddr, ramstore          RAM address and write data
//   ramload, ramstate          RAM read data and status (FREE/BUSY/ACCESS/ERROR)
// -----------------------------------------------------------------------------
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  // icache side
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  // dcache side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_t       state_r;
  arb_state_t       next_state_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic             dreq_s;
  logic             access_s;

  // A write request wins over a simultaneous read; either counts as a request
  assign dreq_s   = dREN | dWEN;
  assign access_s = (ramstate_t'(ramstate) == ACCESS);

  // State register and icache starvation counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= IDLE;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (!iREN) begin
        starve_cnt_r <= {CNT_W{1'b0}};
      end else if ((next_state_s == ISERVE) && (state_r != ISERVE)) begin
        // icache is about to be granted: its wait is over
        starve_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r != ISERVE) && (starve_cnt_r != CNT_MAX)) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end
  end

  // Next-state arbitration; a dropped request aborts, ACCESS completes
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (iREN && (starve_cnt_r == CNT_MAX)) begin
          next_state_s = ISERVE;
        end else if (dreq_s) begin
          next_state_s = DSERVE;
        end else if (iREN) begin
          next_state_s = ISERVE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISERVE: begin
        if (!iREN || access_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = ISERVE;
        end
      end
      DSERVE: begin
        if (!dreq_s || access_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DSERVE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode: RAM port and cache handshakes from state and live inputs
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = {WORD_W{1'b0}};
    ramstore = {WORD_W{1'b0}};
    iload    = {WORD_W{1'b0}};
    dload    = {WORD_W{1'b0}};
    // A requester that is not being served is told to hold
    iwait    = iREN;
    dwait    = dreq_s;
    case (state_r)
      IDLE: begin
        ramREN = 1'b0;
      end
      ISERVE: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          iload   = ramload;
          iwait   = !access_s;
        end else begin
          // Aborted fetch: enables drop now, and no completion pulse is given
          iwait = 1'b1;
        end
      end
      DSERVE: begin
        if (dreq_s) begin
          ramREN   = dREN & !dWEN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          dload    = ramload;
          dwait    = !access_s;
        end else begin
          dwait = 1'b1;
        end
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed-step bench for mem_arbiter. Inputs change 1 time unit after a
// rising CLK edge; outputs are sampled 2 units later, well before the next
// edge. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int W = 32;

  logic         CLK;
  logic         nRST;
  logic         iREN;
  logic [W-1:0] iaddr;
  logic         iwait;
  logic [W-1:0] iload;
  logic         dREN;
  logic         dWEN;
  logic [W-1:0] daddr;
  logic [W-1:0] dstore;
  logic         dwait;
  logic [W-1:0] dload;
  logic         ramREN;
  logic         ramWEN;
  logic [W-1:0] ramaddr;
  logic [W-1:0] ramstore;
  logic [W-1:0] ramload;
  logic [1:0]   ramstate;

  int cmp_cnt = 0;
  int err_cnt = 0;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  mem_arbiter #(.WORD_W(W), .STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // advance to 1 unit after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // let combinational outputs settle after an input change
  task automatic settle();
    #2;
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h0000_0040;
    dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
    ramload = 32'h0; ramstate = S_FREE;

    // ---- reset with icache requesting ----
    #12;
    chk("rst_iwait",  32'(iwait),  32'd1);
    chk("rst_dwait",  32'(dwait),  32'd0);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr,    32'h0);
    chk("rst_iload",  iload,       32'h0);
    nRST = 1'b1;
    tick();                                   // IDLE -> ISERVE
    settle();
    chk("rel_ramREN",  32'(ramREN), 32'd1);
    chk("rel_ramaddr", ramaddr,     32'h0000_0040);

    // ---- single fetch, 2 BUSY cycles then ACCESS ----
    ramstate = S_BUSY; ramload = 32'h2001_0005;
    settle();
    chk("f_busy1_iwait", 32'(iwait), 32'd1);
    tick(); settle();
    chk("f_busy2_iwait",  32'(iwait),  32'd1);
    chk("f_busy2_ramREN", 32'(ramREN), 32'd1);
    ramstate = S_ACCESS;
    settle();
    chk("f_acc_iwait", 32'(iwait), 32'd0);
    chk("f_acc_iload", iload,      32'h2001_0005);
    tick();
    iREN = 1'b0; ramstate = S_FREE;
    settle();
    chk("f_idle_ramREN", 32'(ramREN), 32'd0);
    chk("f_idle_iload",  iload,       32'h0);

    // ---- collision: dcache first, icache right after via IDLE ----
    iREN = 1'b1; iaddr = 32'h0000_0080; dREN = 1'b1; daddr = 32'h0000_0100;
    ramload = 32'h1111_2222;
    settle();
    chk("c_idle_iwait",  32'(iwait),  32'd1);
    chk("c_idle_dwait",  32'(dwait),  32'd1);
    chk("c_idle_ramREN", 32'(ramREN), 32'd0);
    tick(); settle();
    chk("c_d_ramaddr", ramaddr,      32'h0000_0100);
    chk("c_d_ramREN",  32'(ramREN),  32'd1);
    chk("c_d_iwait",   32'(iwait),   32'd1);
    chk("c_d_iload",   iload,        32'h0);
    ramstate = S_ACCESS;
    settle();
    chk("c_d_dwait", 32'(dwait), 32'd0);
    chk("c_d_dload", dload,      32'h1111_2222);
    chk("c_d_iwait_acc", 32'(iwait), 32'd1);
    tick();
    dREN = 1'b0; ramstate = S_FREE;
    settle();
    chk("c_mid_ramREN", 32'(ramREN), 32'd0);
    chk("c_mid_iwait",  32'(iwait),  32'd1);
    tick(); settle();
    chk("c_i_ramaddr", ramaddr,     32'h0000_0080);
    chk("c_i_ramREN",  32'(ramREN), 32'd1);
    ramstate = S_ACCESS; ramload = 32'h3333_4444;
    settle();
    chk("c_i_iwait", 32'(iwait), 32'd0);
    chk("c_i_iload", iload,      32'h3333_4444);
    tick();
    iREN = 1'b0; ramstate = S_FREE;

    // ---- dcache write ----
    dWEN = 1'b1; daddr = 32'h0000_0200; dstore = 32'hDEAD_BEEF;
    tick(); settle();
    chk("w_ramWEN",   32'(ramWEN), 32'd1);
    chk("w_ramREN",   32'(ramREN), 32'd0);
    chk("w_ramaddr",  ramaddr,     32'h0000_0200);
    chk("w_ramstore", ramstore,    32'hDEAD_BEEF);
    chk("w_dwait",    32'(dwait),  32'd1);
    ramstate = S_ACCESS;
    settle();
    chk("w_acc_dwait", 32'(dwait), 32'd0);
    tick();
    dWEN = 1'b0; ramstate = S_FREE;
    settle();
    chk("w_idle_ramWEN", 32'(ramWEN), 32'd0);

    // ---- starvation: dcache hammers, icache forced in after 4 denials ----
    iREN = 1'b1; iaddr = 32'h0000_0044; dREN = 1'b1; daddr = 32'h0000_0300;
    ramstate = S_ACCESS; ramload = 32'h0BAD_F00D;
    tick(); settle();
    chk("s_d1_ramaddr", ramaddr, 32'h0000_0300);
    tick(); settle();
    chk("s_idle1_ramREN", 32'(ramREN), 32'd0);
    tick(); settle();
    chk("s_d2_ramaddr", ramaddr, 32'h0000_0300);
    tick(); settle();
    chk("s_idle2_cnt", 32'(dut.starve_cnt_r), 32'd4);
    tick(); settle();
    chk("s_i_ramaddr", ramaddr,                32'h0000_0044);
    chk("s_i_iwait",   32'(iwait),             32'd0);
    chk("s_i_dwait",   32'(dwait),             32'd1);
    chk("s_i_cnt",     32'(dut.starve_cnt_r),  32'd0);
    tick();
    iREN = 1'b0; dREN = 1'b0; ramstate = S_FREE;

    // ---- abort: dREN dropped during BUSY ----
    dREN = 1'b1; daddr = 32'h0000_0400; ramstate = S_BUSY;
    tick(); settle();
    chk("a_ramREN", 32'(ramREN), 32'd1);
    dREN = 1'b0;
    settle();
    chk("a_drop_ramREN", 32'(ramREN), 32'd0);
    chk("a_drop_dwait",  32'(dwait),  32'd1);
    tick(); settle();
    chk("a_idle_ramREN", 32'(ramREN), 32'd0);

    // ---- ERROR during ISERVE: retried until ACCESS ----
    iREN = 1'b1; iaddr = 32'h0000_0048; ramstate = S_ERROR;
    tick(); settle();
    chk("e1_iwait",  32'(iwait),  32'd1);
    chk("e1_ramREN", 32'(ramREN), 32'd1);
    tick(); settle();
    chk("e2_iwait",   32'(iwait),  32'd1);
    chk("e2_ramREN",  32'(ramREN), 32'd1);
    chk("e2_ramaddr", ramaddr,     32'h0000_0048);
    ramstate = S_ACCESS; ramload = 32'h0000_0055;
    settle();
    chk("e_acc_iwait", 32'(iwait), 32'd0);
    chk("e_acc_iload", iload,      32'h0000_0055);
    tick();
    iREN = 1'b0; ramstate = S_FREE;
    settle();
    chk("e_idle_ramREN", 32'(ramREN), 32'd0);

    // ---- asynchronous reset mid-transaction ----
    iREN = 1'b1; iaddr = 32'h0000_004C; ramstate = S_BUSY;
    tick(); settle();
    chk("r_pre_ramREN", 32'(ramREN), 32'd1);
    nRST = 1'b0;
    #1;
    chk("r_ramREN",  32'(ramREN), 32'd0);
    chk("r_ramaddr", ramaddr,     32'h0);
    chk("r_iwait",   32'(iwait),  32'd1);
    chk("r_iload",   iload,       32'h0);
    #10;
    nRST = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule : tb_mem_arbiter
